// File: rtl/fsic_serial_rx_deframer.sv
// -----------------------------------------------------------------------------
// fsic_serial_rx_deframer
//
// Receive side of the FSIC 12-lane IO serial link. Each frame spans four
// ioclk phases. Lanes 0..7 carry tdata (lane j supplies tdata[j*4+p] at
// phase p), lane 8 tstrb, lane 9 tkeep, lane 10 {tid,tuser}, and lane 11 is
// control: p0 tready, p1 tvalid, p2 tlast, p3 reserved. The block hunts for
// the first lane-11 high sample, takes it as phase 0, then free-runs the
// phase counter. Complete valid frames are pushed into a small FIFO that
// feeds the local axis switch.
//
// Optional build macro: FSIC_RX_FRAME_CHECK_EN
//   Defined   : a set reserved bit at phase 3 is a framing error; the frame
//               is dropped, rx_err_cnt counts it and the block re-hunts.
//   Undefined : the reserved bit is ignored and rx_err_cnt reads 0.
//
// Ports
//   ioclk, axis_rst      clock, synchronous active-high reset
//   rxen                 receive enable (level); low forces IDLE
//   serial_rxd[11:0]     serial lanes
//   is_as_t*             FIFO head beat (zero while the FIFO is empty)
//   is_as_tvalid/tready  downstream handshake
//   remote_tready        tready bit of the latest accepted frame
//   rx_aligned           frame lock held
//   rx_received_data     a frame completed since lock was acquired
//   rx_overflow          sticky: a valid beat was dropped on a full FIFO
//   rx_drop_cnt          saturating dropped-beat count
//   rx_err_cnt           saturating framing-error count
// -----------------------------------------------------------------------------
module fsic_serial_rx_deframer #(
  parameter int pSERIALIO_WIDTH = 12,
  parameter int pDATA_WIDTH     = 32,
  parameter int pCLK_RATIO      = 4,
  parameter int pRxFIFO_DEPTH   = 5
) (
  input  logic                       ioclk,
  input  logic                       axis_rst,
  input  logic                       rxen,
  input  logic [pSERIALIO_WIDTH-1:0] serial_rxd,
  output logic [pDATA_WIDTH-1:0]     is_as_tdata,
  output logic [pCLK_RATIO-1:0]      is_as_tstrb,
  output logic [pCLK_RATIO-1:0]      is_as_tkeep,
  output logic [1:0]                 is_as_tid,
  output logic [1:0]                 is_as_tuser,
  output logic                       is_as_tlast,
  output logic                       is_as_tvalid,
  input  logic                       is_as_tready,
  output logic                       remote_tready,
  output logic                       rx_aligned,
  output logic                       rx_received_data,
  output logic                       rx_overflow,
  output logic [7:0]                 rx_drop_cnt,
  output logic [7:0]                 rx_err_cnt
);

  localparam int DLANES = pDATA_WIDTH / pCLK_RATIO;
  localparam int L_STRB = DLANES;
  localparam int L_KEEP = DLANES + 1;
  localparam int L_IDU  = DLANES + 2;
  localparam int L_CTRL = DLANES + 3;
  localparam int PH_W   = $clog2(pCLK_RATIO);
  localparam int PTR_W  = (pRxFIFO_DEPTH > 1) ? $clog2(pRxFIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(pRxFIFO_DEPTH + 1);
  localparam int BEAT_W = pDATA_WIDTH + 2 * pCLK_RATIO + 4 + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(pRxFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_e                 state_q;
  logic [PH_W-1:0]        phase_q;
  logic                   aligned_q;
  logic                   rcvd_q;
  logic                   rtr_q;

  // Per-lane history of phases 0..2; the phase-3 bit is taken live.
  logic [pCLK_RATIO-2:0]  asm_q [pSERIALIO_WIDTH];
  logic [pCLK_RATIO-1:0]  lane_word [L_CTRL];

  logic [pDATA_WIDTH-1:0] frm_tdata;
  logic [pCLK_RATIO-1:0]  frm_tstrb;
  logic [pCLK_RATIO-1:0]  frm_tkeep;
  logic [3:0]             frm_idu;
  logic [pCLK_RATIO-2:0]  frm_ctrl;   // {tlast, tvalid, tready}
  logic [BEAT_W-1:0]      beat_in;

  logic                   frame_done;
  logic                   frame_err;
  logic                   push_req;

  logic [BEAT_W-1:0]      mem_q [pRxFIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q;
  logic [PTR_W-1:0]       rptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic [7:0]             drop_q;
  logic                   fifo_full;
  logic                   fifo_pop;
  logic                   push_ok;
  logic                   push_drop;
  logic [BEAT_W-1:0]      head;

  // ---- lane assembly ----
  always_ff @(posedge ioclk) begin
    if (rxen) begin
      for (int j = 0; j < pSERIALIO_WIDTH; j++) begin
        asm_q[j] <= {serial_rxd[j], asm_q[j][pCLK_RATIO-2:1]};
      end
    end
  end

  always_comb begin
    for (int j = 0; j < L_CTRL; j++) begin
      lane_word[j] = {serial_rxd[j], asm_q[j]};
    end
    frm_tdata = '0;
    for (int j = 0; j < DLANES; j++) begin
      frm_tdata[j*pCLK_RATIO +: pCLK_RATIO] = lane_word[j];
    end
    frm_tstrb = lane_word[L_STRB];
    frm_tkeep = lane_word[L_KEEP];
    frm_idu   = lane_word[L_IDU];
    frm_ctrl  = asm_q[L_CTRL];
    beat_in   = {frm_tdata, frm_tstrb, frm_tkeep, frm_idu, frm_ctrl[2]};
  end

  assign frame_done = rxen && (state_q == ST_LOCK) &&
                      (phase_q == PH_W'(pCLK_RATIO - 1));

`ifdef FSIC_RX_FRAME_CHECK_EN
  logic [7:0] err_q;

  assign frame_err = frame_done & serial_rxd[L_CTRL];

  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      err_q <= '0;
    end else if (frame_err) begin
      err_q <= sat_inc8(err_q);
    end
  end

  assign rx_err_cnt = err_q;
`else
  assign frame_err  = 1'b0;
  assign rx_err_cnt = '0;
`endif

  assign push_req = frame_done & ~frame_err & frm_ctrl[1];

  // ---- frame state machine ----
  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      aligned_q <= 1'b0;
      rcvd_q    <= 1'b0;
      rtr_q     <= 1'b0;
    end else if (!rxen) begin
      // Any partial frame is abandoned; the FIFO keeps draining.
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      aligned_q <= 1'b0;
      rcvd_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_q <= ST_HUNT;
        ST_HUNT: begin
          if (serial_rxd[L_CTRL]) begin
            state_q   <= ST_LOCK;
            phase_q   <= PH_W'(1);
            aligned_q <= 1'b1;
          end
        end
        ST_LOCK: begin
          phase_q <= phase_q + 1'b1;
          if (frame_done) begin
            if (frame_err) begin
              state_q   <= ST_HUNT;
              phase_q   <= '0;
              aligned_q <= 1'b0;
            end else begin
              rtr_q  <= frm_ctrl[0];
              rcvd_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- receive FIFO ----
  assign fifo_full = (cnt_q == CNT_W'(pRxFIFO_DEPTH));
  assign fifo_pop  = (cnt_q != '0) & is_as_tready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok   = push_req & (~fifo_full | fifo_pop);
  assign push_drop = push_req & fifo_full & ~fifo_pop;

  always_ff @(posedge ioclk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= beat_in;
    end
  end

  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (fifo_pop) rptr_q <= ptr_inc(rptr_q);
      unique case ({push_ok, fifo_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_drop) begin
        ovf_q  <= 1'b1;
        drop_q <= sat_inc8(drop_q);
      end
    end
  end

  assign head         = mem_q[rptr_q];
  assign is_as_tvalid = (cnt_q != '0);
  assign {is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast} =
         is_as_tvalid ? head : '0;

  assign remote_tready    = rtr_q;
  assign rx_aligned       = aligned_q;
  assign rx_received_data = rcvd_q;
  assign rx_overflow      = ovf_q;
  assign rx_drop_cnt      = drop_q;

endmodule

// File: tb/tb_fsic_serial_rx_deframer.sv
// -----------------------------------------------------------------------------
// Testbench for fsic_serial_rx_deframer. Frames are built from field values,
// serialised onto the lanes, and a queue-based reference model tracks lock,
// the FIFO contents and the status outputs.
// -----------------------------------------------------------------------------
module tb_fsic_serial_rx_deframer;

  localparam int DEPTH = 5;
`ifdef FSIC_RX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        ioclk = 1'b0;
  logic        rst_r;
  logic        rxen_r;
  logic [11:0] rxd_r;
  logic        rdy_r;

  logic [31:0] is_as_tdata;
  logic [3:0]  is_as_tstrb, is_as_tkeep;
  logic [1:0]  is_as_tid, is_as_tuser;
  logic        is_as_tlast, is_as_tvalid;
  logic        remote_tready, rx_aligned, rx_received_data, rx_overflow;
  logic [7:0]  rx_drop_cnt, rx_err_cnt;

  always #5 ioclk = ~ioclk;

  fsic_serial_rx_deframer dut (
    .ioclk            (ioclk),
    .axis_rst         (rst_r),
    .rxen             (rxen_r),
    .serial_rxd       (rxd_r),
    .is_as_tdata      (is_as_tdata),
    .is_as_tstrb      (is_as_tstrb),
    .is_as_tkeep      (is_as_tkeep),
    .is_as_tid        (is_as_tid),
    .is_as_tuser      (is_as_tuser),
    .is_as_tlast      (is_as_tlast),
    .is_as_tvalid     (is_as_tvalid),
    .is_as_tready     (rdy_r),
    .remote_tready    (remote_tready),
    .rx_aligned       (rx_aligned),
    .rx_received_data (rx_received_data),
    .rx_overflow      (rx_overflow),
    .rx_drop_cnt      (rx_drop_cnt),
    .rx_err_cnt       (rx_err_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic [1:0]  id;
    logic [1:0]  us;
    logic        last;
    logic        vld;
    logic        rdy;
    logic        rsvd;
  } frm_t;

  // Reference model: 0 idle, 1 hunting, 2 locked.
  int          m_mode, m_phase, m_drop, m_err;
  logic [11:0] m_smp [4];
  logic [44:0] m_q [$];
  bit          m_ovf, m_rtr, m_recv, m_aln;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          pop, push;
    logic [44:0] nb;
    logic [31:0] d;
    logic [3:0]  s, k, iu;
    if (rst_r) begin
      m_mode = 0; m_phase = 0; m_drop = 0; m_err = 0;
      m_ovf = 0; m_rtr = 0; m_recv = 0; m_aln = 0;
      m_q.delete();
      return;
    end
    pop  = rdy_r && (m_q.size() > 0);
    push = 0;
    nb   = '0;
    if (!rxen_r) begin
      m_mode = 0; m_phase = 0; m_aln = 0; m_recv = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rxd_r[11]) begin
        m_smp[0] = rxd_r; m_phase = 1; m_mode = 2; m_aln = 1;
      end
    end else begin
      m_smp[m_phase] = rxd_r;
      if (m_phase == 3) begin
        m_phase = 0;
        if (CHK && rxd_r[11]) begin
          if (m_err < 255) m_err++;
          m_mode = 1; m_aln = 0;
        end else begin
          for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 8; j++) d[j*4+p] = m_smp[p][j];
            s[p]  = m_smp[p][8];
            k[p]  = m_smp[p][9];
            iu[p] = m_smp[p][10];
          end
          m_rtr  = m_smp[0][11];
          m_recv = 1;
          push   = m_smp[1][11];
          nb     = {d, s, k, iu, m_smp[2][11]};
        end
      end else begin
        m_phase++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(nb);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("tvalid", is_as_tvalid, m_q.size() != 0);
    if (m_q.size() != 0)
      check_eq("head", {is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast}, m_q[0]);
    check_eq("remote_tready", remote_tready, m_rtr);
    check_eq("rx_aligned", rx_aligned, m_aln);
    check_eq("rx_received_data", rx_received_data, m_recv);
    check_eq("rx_overflow", rx_overflow, m_ovf);
    check_eq("rx_drop_cnt", rx_drop_cnt, m_drop);
    check_eq("rx_err_cnt", rx_err_cnt, m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge ioclk);
    #1;
    compare_all();
  endtask

  function automatic logic [11:0] lanes_of(input frm_t f, input int p);
    logic [11:0] r;
    logic [3:0]  iu;
    iu = {f.id, f.us};
    for (int j = 0; j < 8; j++) r[j] = f.d[j*4+p];
    r[8]  = f.s[p];
    r[9]  = f.k[p];
    r[10] = iu[p];
    case (p)
      0:       r[11] = f.rdy;
      1:       r[11] = f.vld;
      2:       r[11] = f.last;
      default: r[11] = f.rsvd;
    endcase
    return r;
  endfunction

  task automatic drive_phase(input frm_t f, input int p, input logic r);
    rxd_r = lanes_of(f, p);
    rdy_r = r;
    tick();
  endtask

  task automatic send_frame(input frm_t f, input logic [3:0] rmask);
    for (int p = 0; p < 4; p++) drive_phase(f, p, rmask[p]);
  endtask

  function automatic frm_t rand_frame();
    frm_t f;
    f.d    = $urandom;
    f.s    = 4'($urandom_range(0, 15));
    f.k    = 4'($urandom_range(0, 15));
    f.id   = 2'($urandom_range(0, 3));
    f.us   = 2'($urandom_range(0, 3));
    f.last = 1'($urandom_range(0, 1));
    f.vld  = 1'b1;
    f.rdy  = 1'b1;
    f.rsvd = 1'b0;
    return f;
  endfunction

  function automatic frm_t idle_frame();
    frm_t f;
    f = '0;
    f.rdy = 1'b1;
    return f;
  endfunction

  initial begin
    frm_t f;
    rst_r = 1'b1; rxen_r = 1'b0; rxd_r = '0; rdy_r = 1'b0;
    tick();
    tick();
    // Reset state
    check_eq("rst_tvalid", is_as_tvalid, 0);
    check_eq("rst_head", {is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast}, 0);
    check_eq("rst_status", {remote_tready, rx_aligned, rx_received_data, rx_overflow}, 0);
    check_eq("rst_cnts", {rx_drop_cnt, rx_err_cnt}, 0);
    rst_r = 1'b0;
    rxen_r = 1'b1;
    tick();
    tick();

    // Test 1: single known frame
    f = '{d: 32'hA5C3_1F07, s: 4'hF, k: 4'hF, id: 2'd2, us: 2'd1,
          last: 1'b1, vld: 1'b1, rdy: 1'b1, rsvd: 1'b0};
    for (int p = 0; p < 3; p++) drive_phase(f, p, 1'b0);
    check_eq("t1_tvalid_before", is_as_tvalid, 0);
    drive_phase(f, 3, 1'b0);
    check_eq("t1_tvalid", is_as_tvalid, 1);
    check_eq("t1_tdata", is_as_tdata, 32'hA5C3_1F07);
    check_eq("t1_tstrb", is_as_tstrb, 4'hF);
    check_eq("t1_tkeep", is_as_tkeep, 4'hF);
    check_eq("t1_tid", is_as_tid, 2'd2);
    check_eq("t1_tuser", is_as_tuser, 2'd1);
    check_eq("t1_tlast", is_as_tlast, 1);
    check_eq("t1_rtr", remote_tready, 1);
    check_eq("t1_recv", rx_received_data, 1);
    check_eq("t1_aligned", rx_aligned, 1);
    send_frame(idle_frame(), 4'hF);
    check_eq("t1_drained", is_as_tvalid, 0);

    // Test 4: tvalid=0, tready=0 frame
    f = idle_frame();
    f.rdy = 1'b0;
    f.d = 32'hDEAD_BEEF;
    send_frame(f, 4'h0);
    check_eq("t4_rtr", remote_tready, 0);
    check_eq("t4_nopush", is_as_tvalid, 0);

    // Test 2: overflow with depth 5
    rst_r = 1'b1; rxd_r = '0; tick();
    rst_r = 1'b0; tick();
    for (int i = 0; i < 6; i++) send_frame(rand_frame(), 4'h0);
    check_eq("t2_tvalid", is_as_tvalid, 1);
    check_eq("t2_ovf", rx_overflow, 1);
    check_eq("t2_drop", rx_drop_cnt, 8'd1);
    send_frame(idle_frame(), 4'hF);
    send_frame(idle_frame(), 4'hF);
    check_eq("t2_drained", is_as_tvalid, 0);

    // Test 3: full FIFO, pop on the completing edge
    for (int i = 0; i < 5; i++) send_frame(rand_frame(), 4'h0);
    check_eq("t3_drop_before", rx_drop_cnt, 8'd1);
    send_frame(rand_frame(), 4'b1000);
    check_eq("t3_drop_after", rx_drop_cnt, 8'd1);
    check_eq("t3_tvalid", is_as_tvalid, 1);
    send_frame(idle_frame(), 4'hF);
    send_frame(idle_frame(), 4'hF);
    check_eq("t3_drained", is_as_tvalid, 0);

    // Test 5: rxen falls at phase 2
    send_frame(rand_frame(), 4'h0);
    send_frame(rand_frame(), 4'h0);
    f = rand_frame();
    drive_phase(f, 0, 1'b0);
    drive_phase(f, 1, 1'b0);
    rxen_r = 1'b0;
    drive_phase(f, 2, 1'b0);
    check_eq("t5_aligned", rx_aligned, 0);
    check_eq("t5_recv", rx_received_data, 0);
    check_eq("t5_kept", is_as_tvalid, 1);
    rxd_r = '0; rdy_r = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t5_drained", is_as_tvalid, 0);
    rdy_r = 1'b0;

    // Test 6: reserved bit set at phase 3
    rxen_r = 1'b1;
    tick();
    tick();
    f = rand_frame();
    f.rsvd = 1'b1;
    send_frame(f, 4'h0);
`ifdef FSIC_RX_FRAME_CHECK_EN
    check_eq("t6_err", rx_err_cnt, 8'd1);
    check_eq("t6_aligned", rx_aligned, 0);
    check_eq("t6_nopush", is_as_tvalid, 0);
`else
    check_eq("t6_push", is_as_tvalid, 1);
    check_eq("t6_err", rx_err_cnt, 8'd0);
    check_eq("t6_aligned", rx_aligned, 1);
`endif
    send_frame(idle_frame(), 4'hF);

    // Randomised traffic with enable drops and resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst_r = 1'b1; rxd_r = 12'($urandom); rdy_r = 1'($urandom_range(0, 1));
        tick();
        rst_r = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) begin
        rxen_r = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          rxd_r = 12'($urandom); rdy_r = 1'($urandom_range(0, 1));
          tick();
        end
        rxen_r = 1'b1;
      end
      f = rand_frame();
      f.vld  = 1'($urandom_range(0, 3) != 0);
      f.rdy  = 1'($urandom_range(0, 3) != 0);
      f.rsvd = 1'($urandom_range(0, 9) == 0);
      send_frame(f, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
